// File: rtl/cfg_vpd_pkg.sv
// Shared types and constants for the VPD capability request sequencer.
// The optional timeout (CFG_VPD_TIMEOUT_EN) uses the same error bit indices.
package cfg_vpd_pkg;

  localparam int VPD_ADDR_W = 15;

  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_OVERLAP = 1;
  localparam int ERR_UNIMPL  = 2;
  localparam int ERR_W       = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DRAIN   = 2'd3
  } state_e;

endpackage

// File: rtl/cfg_vpd_timeout.sv
// Cycle counter for a pending VPD request; only instantiated when
// CFG_VPD_TIMEOUT_EN is defined. expired is high in the TIMEOUT_CYCLES-th enabled cycle.
module cfg_vpd_timeout #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clock_tlx,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  logic [15:0] count;

  assign expired = enable && (count == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock_tlx or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/cfg_vpd_req_seq.sv
// Turns host writes of the VPD capability address/flag register into one read or
// write request to the downstream VPD stage. Optional timeout: CFG_VPD_TIMEOUT_EN.
import cfg_vpd_pkg::*;

module cfg_vpd_req_seq #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clock_tlx,
  input  logic                  reset,
  input  logic                  cap_addr_we,
  input  logic [15:0]           cap_addr_wdata,
  input  logic                  cap_data_we,
  input  logic [31:0]           cap_data_wdata,
  output logic                  cap_flag,
  output logic [VPD_ADDR_W-1:0] cap_addr,
  output logic [31:0]           cap_data,
  output logic                  busy,
  output logic [ERR_W-1:0]      err_sticky,
  input  logic                  err_clear,
  output logic [VPD_ADDR_W-1:0] cfg_vpd_addr,
  output logic                  cfg_vpd_wren,
  output logic [31:0]           cfg_vpd_wdata,
  output logic                  cfg_vpd_rden,
  input  logic [31:0]           vpd_cfg_rdata,
  input  logic                  vpd_cfg_done,
  input  logic                  vpd_err_unimplemented_addr,
  output state_e                dbg_state
);

  state_e                state, state_next;
  logic                  flag_d, rden_d, wren_d;
  logic [VPD_ADDR_W-1:0] addr_d, vaddr_d;
  logic [31:0]           data_d, vwdata_d;
  logic [ERR_W-1:0]      err_set, err_d;
  logic                  waiting, timeout_expired;

  assign waiting   = (state == RD_WAIT) || (state == WR_WAIT);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

`ifdef CFG_VPD_TIMEOUT_EN
  cfg_vpd_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock_tlx (clock_tlx),
    .reset     (reset),
    .enable    (waiting),
    .clear     (!waiting),
    .expired   (timeout_expired)
  );
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = (TIMEOUT_CYCLES > 0);
  assign timeout_expired       = 1'b0;
`endif

  always_comb begin
    state_next = state;
    flag_d     = cap_flag;
    addr_d     = cap_addr;
    data_d     = cap_data;
    vaddr_d    = cfg_vpd_addr;
    vwdata_d   = cfg_vpd_wdata;
    rden_d     = cfg_vpd_rden;
    wren_d     = cfg_vpd_wren;

    err_set              = '0;
    err_set[ERR_OVERLAP] = cap_addr_we && busy;
    err_set[ERR_UNIMPL]  = waiting && vpd_err_unimplemented_addr;
    // A done arriving in the expiry cycle completes normally.
    err_set[ERR_TIMEOUT] = waiting && !vpd_cfg_done && timeout_expired;

    case (state)
      IDLE: begin
        if (cap_data_we) data_d = cap_data_wdata;
        if (cap_addr_we) begin
          addr_d  = cap_addr_wdata[VPD_ADDR_W-1:0];
          vaddr_d = cap_addr_wdata[VPD_ADDR_W-1:0];
          flag_d  = cap_addr_wdata[15];
          if (cap_addr_wdata[15]) begin
            state_next = WR_WAIT;
            wren_d     = 1'b1;
            // Forward a same-cycle data write so the request carries the newest value.
            vwdata_d   = data_d;
          end else begin
            state_next = RD_WAIT;
            rden_d     = 1'b1;
          end
        end
      end
      RD_WAIT: begin
        if (vpd_cfg_done) begin
          data_d     = vpd_cfg_rdata;
          flag_d     = 1'b1;
          rden_d     = 1'b0;
          state_next = DRAIN;
        end else if (timeout_expired) begin
          rden_d     = 1'b0;
          state_next = DRAIN;
        end
      end
      WR_WAIT: begin
        if (vpd_cfg_done) begin
          flag_d     = 1'b0;
          wren_d     = 1'b0;
          state_next = DRAIN;
        end else if (timeout_expired) begin
          wren_d     = 1'b0;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Clear first, then OR in new events so a same-cycle error survives the clear.
    err_d = (err_clear ? '0 : err_sticky) | err_set;
  end

  always_ff @(posedge clock_tlx or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cap_flag      <= 1'b0;
      cap_addr      <= '0;
      cap_data      <= '0;
      err_sticky    <= '0;
      cfg_vpd_addr  <= '0;
      cfg_vpd_wdata <= '0;
      cfg_vpd_rden  <= 1'b0;
      cfg_vpd_wren  <= 1'b0;
    end else begin
      state         <= state_next;
      cap_flag      <= flag_d;
      cap_addr      <= addr_d;
      cap_data      <= data_d;
      err_sticky    <= err_d;
      cfg_vpd_addr  <= vaddr_d;
      cfg_vpd_wdata <= vwdata_d;
      cfg_vpd_rden  <= rden_d;
      cfg_vpd_wren  <= wren_d;
    end
  end

endmodule

// File: tb/tb_cfg_vpd_req_seq.sv
// Directed bench for cfg_vpd_req_seq: a driver issues requests and pushes the expected
// completion record; a monitor builds the observed record when busy falls and compares.
module tb_cfg_vpd_req_seq;

  localparam int TO_CYCLES = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cap_addr_we, cap_data_we, err_clear;
  logic [15:0] cap_addr_wdata;
  logic [31:0] cap_data_wdata, vpd_cfg_rdata;
  logic        vpd_cfg_done, vpd_err_unimplemented_addr;
  logic        cap_flag, busy, cfg_vpd_wren, cfg_vpd_rden;
  logic [14:0] cap_addr, cfg_vpd_addr;
  logic [31:0] cap_data, cfg_vpd_wdata;
  logic [2:0]  err_sticky;
  cfg_vpd_pkg::state_e dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // {flag, data, err, active cycles, drain cycles, addr, wdata, stable}
  logic [95:0] exp_q[$];
  logic [31:0] exp_data;
  logic [2:0]  exp_err;

  cfg_vpd_req_seq #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
    .clock_tlx                  (clk),
    .reset                      (rst),
    .cap_addr_we                (cap_addr_we),
    .cap_addr_wdata             (cap_addr_wdata),
    .cap_data_we                (cap_data_we),
    .cap_data_wdata             (cap_data_wdata),
    .cap_flag                   (cap_flag),
    .cap_addr                   (cap_addr),
    .cap_data                   (cap_data),
    .busy                       (busy),
    .err_sticky                 (err_sticky),
    .err_clear                  (err_clear),
    .cfg_vpd_addr               (cfg_vpd_addr),
    .cfg_vpd_wren               (cfg_vpd_wren),
    .cfg_vpd_wdata              (cfg_vpd_wdata),
    .cfg_vpd_rden               (cfg_vpd_rden),
    .vpd_cfg_rdata              (vpd_cfg_rdata),
    .vpd_cfg_done               (vpd_cfg_done),
    .vpd_err_unimplemented_addr (vpd_err_unimplemented_addr),
    .dbg_state                  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, got running, required finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [95:0] pack_rec(input logic flag, input logic [31:0] data,
                                           input logic [2:0] err, input logic [7:0] act,
                                           input logic [3:0] drain, input logic [14:0] addr,
                                           input logic [31:0] wdata, input logic stable);
    return {flag, data, err, act, drain, addr, wdata, stable};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, got, exp);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy; i++) tick();
    check("wait_idle", {127'd0, busy}, 128'd0);
  endtask

  task automatic run_req(input logic wr, input logic [14:0] addr, input logic [31:0] val,
                         input int wait_n, input logic give_done, input logic unimpl);
    logic [31:0] e_data;
    logic        e_flag;
    logic [2:0]  e_err;
    e_err = exp_err | (unimpl ? 3'b100 : 3'b000) | (give_done ? 3'b000 : 3'b001);
    if (wr) begin
      e_data = val;
      e_flag = !give_done;
    end else begin
      e_data = give_done ? val : exp_data;
      e_flag = give_done;
    end
    exp_q.push_back(pack_rec(e_flag, e_data, e_err, 8'(wait_n), 4'd1, addr,
                             wr ? val : 32'd0, 1'b1));
    exp_data = e_data;
    exp_err  = e_err;
    if (wr) begin
      cap_data_we = 1'b1; cap_data_wdata = val;
      tick();
      cap_data_we = 1'b0;
    end
    cap_addr_we = 1'b1; cap_addr_wdata = {wr, addr};
    tick();
    cap_addr_we = 1'b0;
    for (int k = 1; k <= wait_n; k++) begin
      // a data write during the request must be ignored
      if (k == 1 && wr) begin
        cap_data_we = 1'b1; cap_data_wdata = ~val;
      end
      if (k == wait_n && give_done) begin
        vpd_cfg_done  = 1'b1;
        vpd_cfg_rdata = wr ? 32'hFFFF_0000 : val;
        vpd_err_unimplemented_addr = unimpl;
      end
      tick();
      cap_data_we = 1'b0; vpd_cfg_done = 1'b0; vpd_err_unimplemented_addr = 1'b0;
    end
    wait_idle();
  endtask

  task automatic clear_errors();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    exp_err = 3'b000;
    check("err_clear", {125'd0, err_sticky}, 128'd0);
  endtask

  // scoreboard monitor
  initial begin
    logic        prev_busy, m_seen, m_stable;
    logic [14:0] m_addr;
    logic [31:0] m_wdata;
    logic [95:0] got;
    int          act_n, drain_n;
    prev_busy = 1'b0; m_seen = 1'b0; m_stable = 1'b1;
    m_addr = '0; m_wdata = '0; act_n = 0; drain_n = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_busy = 1'b0; m_seen = 1'b0; m_stable = 1'b1; act_n = 0; drain_n = 0;
      end else begin
        if (busy) begin
          if (cfg_vpd_rden || cfg_vpd_wren) begin
            if (!m_seen) begin
              m_addr  = cfg_vpd_addr;
              m_wdata = cfg_vpd_wren ? cfg_vpd_wdata : 32'd0;
              m_seen  = 1'b1;
            end else if (cfg_vpd_addr !== m_addr ||
                         (cfg_vpd_wren && cfg_vpd_wdata !== m_wdata)) begin
              m_stable = 1'b0;
            end
            act_n++;
          end else begin
            drain_n++;
          end
        end else if (prev_busy) begin
          got = pack_rec(cap_flag, cap_data, err_sticky, 8'(act_n), 4'(drain_n),
                         m_addr, m_wdata, m_stable);
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL completion_unexpected: got %h, required no completion", got);
          end else begin
            check("completion", {32'd0, got}, {32'd0, exp_q.pop_front()});
          end
          m_seen = 1'b0; m_stable = 1'b1; act_n = 0; drain_n = 0;
        end
        prev_busy = busy;
      end
    end
  end

  // stimulus
  initial begin
    rst = 1'b1;
    cap_addr_we = 1'b0; cap_addr_wdata = '0; cap_data_we = 1'b0; cap_data_wdata = '0;
    err_clear = 1'b0; vpd_cfg_rdata = '0; vpd_cfg_done = 1'b0; vpd_err_unimplemented_addr = 1'b0;
    exp_data = '0; exp_err = '0;
    repeat (3) tick();
    check("reset_state", {busy, cap_flag, cap_addr, cap_data, err_sticky, cfg_vpd_addr,
                          cfg_vpd_wdata, cfg_vpd_rden, cfg_vpd_wren}, 128'd0);
    rst = 1'b0;
    tick();

    // basic read: done in the 5th wait cycle
    run_req(1'b0, 15'h0010, 32'hDEAD_BEEF, 5, 1'b1, 1'b0);

    // done while idle is ignored
    vpd_cfg_done = 1'b1; vpd_cfg_rdata = 32'h1111_1111;
    tick();
    vpd_cfg_done = 1'b0;
    tick();
    check("idle_done_ignored", {busy, cap_flag, cap_data}, {94'd0, 1'b1, 32'hDEAD_BEEF});

    // basic write, done in the 3rd wait cycle
    run_req(1'b1, 15'h7FFC, 32'h1234_5678, 3, 1'b1, 1'b0);

    // overlapping address write during RD_WAIT, then clear racing a new overlap
    exp_q.push_back(pack_rec(1'b1, 32'hCAFE_F00D, 3'b010, 8'd4, 4'd1, 15'h0020, 32'd0, 1'b1));
    cap_addr_we = 1'b1; cap_addr_wdata = 16'h0020;
    tick();
    cap_addr_we = 1'b0;
    tick();
    cap_addr_we = 1'b1; cap_addr_wdata = 16'h8055;
    tick();
    err_clear = 1'b1;
    tick();
    cap_addr_we = 1'b0; err_clear = 1'b0;
    check("overlap_set_wins", {125'd0, err_sticky}, {125'd0, 3'b010});
    vpd_cfg_done = 1'b1; vpd_cfg_rdata = 32'hCAFE_F00D;
    tick();
    vpd_cfg_done = 1'b0;
    wait_idle();
    exp_data = 32'hCAFE_F00D;
    clear_errors();

    // unimplemented address flagged by the VPD stage, done in the first wait cycle
    run_req(1'b0, 15'h7FFF, 32'h0000_0000, 1, 1'b1, 1'b1);
    clear_errors();

`ifdef CFG_VPD_TIMEOUT_EN
    // no done: request abandoned after TO_CYCLES
    run_req(1'b0, 15'h0030, 32'h0, TO_CYCLES, 1'b0, 1'b0);
    clear_errors();
    // done exactly in the expiry cycle completes normally
    run_req(1'b0, 15'h0031, 32'h5A5A_5A5A, TO_CYCLES, 1'b1, 1'b0);
`endif

    // reset in the middle of WR_WAIT
    cap_data_we = 1'b1; cap_data_wdata = 32'h0BAD_F00D;
    tick();
    cap_data_we = 1'b0; cap_addr_we = 1'b1; cap_addr_wdata = 16'h8100;
    tick();
    cap_addr_we = 1'b0;
    tick();
    check("wren_before_reset", {126'd0, busy, cfg_vpd_wren}, {126'd0, 2'b11});
    #2;
    rst = 1'b1;
    #1;
    check("reset_mid_write", {busy, cap_flag, cap_addr, cap_data, err_sticky, cfg_vpd_addr,
                              cfg_vpd_wdata, cfg_vpd_rden, cfg_vpd_wren}, 128'd0);
    tick();
    rst = 1'b0;
    exp_data = '0; exp_err = '0;
    tick();

    run_req(1'b0, 15'h0040, 32'h1357_9BDF, 1, 1'b1, 1'b0);

    repeat (3) tick();
    check("queue_empty", 128'(exp_q.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cfg_vpd_req_seq.md
CFG_VPD_REQ_SEQ -- requirements
Module: cfg_vpd_req_seq

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 4096, meaning max cycles a request waits for vpd_cfg_done (legal 2..65535).
REQ-002 Port: clock_tlx  input  1  sole clock; all logic on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: cap_addr_we  input  1  one-cycle strobe, config write to VPD capability address/flag register.
REQ-005 Port: cap_addr_wdata  input  16  bit 15 = F flag (1 = write request), bits 14:0 = VPD byte address.
REQ-006 Port: cap_data_we  input  1  one-cycle strobe, config write to VPD capability data register.
REQ-007 Port: cap_data_wdata  input  32  data register write value.
REQ-008 Port: cap_flag  output  1  F flag as read by host.
REQ-009 Port: cap_addr  output  15  latched VPD address.
REQ-010 Port: cap_data  output  32  data register as read by host.
REQ-011 Port: busy  output  1  request outstanding.
REQ-012 Port: err_sticky  output  3  bit0 timeout, bit1 overlap (address write while busy), bit2 unimplemented address.
REQ-013 Port: err_clear  input  1  one-cycle strobe clearing err_sticky.
REQ-014 Ports to downstream VPD stage: cfg_vpd_addr out 15, cfg_vpd_wren out 1, cfg_vpd_wdata out 32, cfg_vpd_rden out 1, vpd_cfg_rdata in 32, vpd_cfg_done in 1, vpd_err_unimplemented_addr in 1.

Function
REQ-015 FSM states SHALL be IDLE, RD_WAIT, WR_WAIT, DRAIN.
REQ-016 IDLE + cap_addr_we with F=0: latch addr, cap_flag<=0, go RD_WAIT; cfg_vpd_rden=1 from next cycle.
REQ-017 IDLE + cap_addr_we with F=1: latch addr, cap_flag<=1, go WR_WAIT; cfg_vpd_wren=1, cfg_vpd_wdata=cap_data from next cycle.
REQ-018 rden/wren, cfg_vpd_addr, cfg_vpd_wdata SHALL be registered and held stable through the whole WAIT state.
REQ-019 vpd_cfg_done in RD_WAIT: next cycle cap_data<=vpd_cfg_rdata, cap_flag<=1, rden<=0, state DRAIN.
REQ-020 vpd_cfg_done in WR_WAIT: next cycle cap_flag<=0, wren<=0, state DRAIN.
REQ-021 DRAIN lasts exactly one cycle with rden=wren=0, then IDLE; busy=1 in RD_WAIT, WR_WAIT, DRAIN.
REQ-022 vpd_cfg_done outside WAIT states SHALL be ignored.
REQ-023 vpd_err_unimplemented_addr high in a WAIT state SHALL set err_sticky[2].
REQ-024 cap_addr_we while busy SHALL be ignored (no latch, no flag change) and set err_sticky[1].
REQ-025 cap_data_we SHALL update cap_data only when state is IDLE; ignored otherwise.
REQ-026 err_clear and a same-cycle error set: set wins.

Reset
REQ-027 Reset SHALL force IDLE, cap_flag=0, cap_addr=0, cap_data=0, busy=0, err_sticky=0, cfg_vpd_addr=0, cfg_vpd_wdata=0, rden=wren=0 immediately, including mid-request.

Configuration
REQ-028 Macro CFG_VPD_TIMEOUT_EN defined: WAIT-state cycle counter; at TIMEOUT_CYCLES cycles without done, drop rden/wren, leave cap_flag unchanged, set err_sticky[0], go DRAIN; done in the expiry cycle wins over timeout.
REQ-029 Macro undefined: no counter, WAIT states exit only on vpd_cfg_done, err_sticky[0] tied 0.

Structure
REQ-030 Shared package cfg_vpd_pkg SHALL hold the FSM state enum, error bit index constants, and VPD address width (15).
REQ-031 Optional timeout logic SHALL be sub-module cfg_vpd_timeout (enable, clear, expired), instantiated only under CFG_VPD_TIMEOUT_EN.

Verification
REQ-032 Read: cap_addr_we F=0 addr 0x0010; done after 5 cycles with rdata 0xDEADBEEF -> rden high 5 cycles, cap_data=0xDEADBEEF, cap_flag=1, busy low 2 cycles after done.
REQ-033 Write: cap_data_we 0x12345678, cap_addr_we F=1 addr 0x7FFC; done after 3 cycles -> wren+wdata=0x12345678 held until done, cap_flag=0 after.
REQ-034 Overlap: second cap_addr_we during RD_WAIT -> cfg_vpd_addr unchanged, err_sticky=3'b010; err_clear -> 0.
REQ-035 Timeout (macro on, TIMEOUT_CYCLES=8): no done -> rden drops after 8 cycles, err_sticky[0]=1, cap_flag stays 0; done on cycle 8 -> normal completion, no error.
REQ-036 Reset asserted mid WR_WAIT -> wren=0 same cycle, all outputs zero, following read completes normally.
